// File: rtl/vector_pkg.sv
// Shared types and constants for the vector unit to scratchpad write path.
package vector_pkg;

  localparam int unsigned NUM_ELEMENTS = 32;
  localparam int unsigned BEAT_ELEMS   = 8;
  localparam int unsigned FIFO_DEPTH   = 2;

  localparam int unsigned SPAD_ROWS = 4096;
  localparam int unsigned SPAD_COLS = 4096;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned ROW_ID_W  = 6;
  localparam int unsigned ERR_W     = 5;

  localparam int unsigned ERR_ROW_RANGE = 0;
  localparam int unsigned ERR_COL_RANGE = 1;
  localparam int unsigned ERR_DTYPE     = 2;

  typedef enum logic [1:0] {
    DT_FP16 = 2'd0,
    DT_BF16 = 2'd1,
    DT_FP32 = 2'd2,
    DT_INT8 = 2'd3
  } dtype_t;

  typedef struct packed {
    logic [NUM_ELEMENTS*16-1:0] vdata;
    logic [NUM_ELEMENTS-1:0]    vmask;
    logic [ADDR_W-1:0]          row;
    logic [ADDR_W-1:0]          col;
    logic [ROW_ID_W-1:0]        row_id;
    logic                       swizzle;
    dtype_t                     dtype;
  } spad_wr_req_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ISSUE,
    DONE
  } spwr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; also exposes the entry behind the head so the consumer
// can chain straight into the next item on the cycle it pops.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic             has_next,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] rd_next
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Fullness is taken from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign has_next = (count_q > CntW'(1));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head     = mem[rd_ptr_q];
  assign rd_next  = mem[ptr_inc(rd_ptr_q)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/vector_spad_writer.sv
// Receives vector register write requests, checks them, and serialises them into
// scratchpad write beats (row-wide or transposed), then reports completion.
module vector_spad_writer
  import vector_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [NUM_ELEMENTS*16-1:0]  req_vdata,
  input  logic [NUM_ELEMENTS-1:0]     req_vmask,
  input  logic [ADDR_W-1:0]           req_row,
  input  logic [ADDR_W-1:0]           req_col,
  input  logic [ROW_ID_W-1:0]         req_row_id,
  input  logic                        req_swizzle,
  input  logic [1:0]                  req_dtype,
  output logic                        spad_valid,
  input  logic                        spad_ready,
  output logic [ADDR_W-1:0]           spad_row,
  output logic [ADDR_W-1:0]           spad_col,
  output logic [BEAT_ELEMS*16-1:0]    spad_data,
  output logic [BEAT_ELEMS-1:0]       spad_strb,
  output logic                        done_valid,
  output logic [ROW_ID_W-1:0]         done_row_id,
  output logic [ERR_W-1:0]            error
);

  localparam int unsigned IdxW     = $clog2(NUM_ELEMENTS);
  localparam int unsigned RowBeats = NUM_ELEMENTS / BEAT_ELEMS;
  localparam int unsigned BeatW    = BEAT_ELEMS * 16;
  localparam int unsigned ReqW     = $bits(spad_wr_req_t);

  typedef struct packed {
    logic            found;
    logic [IdxW-1:0] idx;
  } beat_sel_t;

  function automatic logic [BEAT_ELEMS-1:0] beat_strb(spad_wr_req_t r, int unsigned k);
    logic [BEAT_ELEMS-1:0] s;
    s = '0;
    if (r.swizzle) s[0] = 1'(r.vmask >> k);
    else           s    = BEAT_ELEMS'(r.vmask >> (k * BEAT_ELEMS));
    return s;
  endfunction

  // First beat at or after 'start' that carries at least one enabled lane.
  function automatic beat_sel_t next_beat(spad_wr_req_t r, int unsigned start);
    beat_sel_t   sel;
    int unsigned nbeats;
    int unsigned j;
    sel    = '0;
    nbeats = r.swizzle ? NUM_ELEMENTS : RowBeats;
    for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
      j = NUM_ELEMENTS - 1 - i;
      if (j >= start && j < nbeats && |beat_strb(r, j)) begin
        sel.found = 1'b1;
        sel.idx   = IdxW'(j);
      end
    end
    return sel;
  endfunction

  function automatic logic [ERR_W-1:0] check_errors(spad_wr_req_t r);
    logic [ADDR_W:0]  row_end, col_end;
    logic [ERR_W-1:0] e;
    row_end = {1'b0, r.row} + (ADDR_W + 1)'(NUM_ELEMENTS - 1);
    col_end = {1'b0, r.col} + (ADDR_W + 1)'(NUM_ELEMENTS - 1);
    e = '0;
    e[ERR_ROW_RANGE] = r.swizzle && (row_end > (ADDR_W + 1)'(SPAD_ROWS - 1));
    e[ERR_COL_RANGE] = !r.swizzle && (col_end > (ADDR_W + 1)'(SPAD_COLS - 1));
    e[ERR_DTYPE]     = (r.dtype != DT_FP16);
    return e;
  endfunction

  spad_wr_req_t  fifo_wdata, fifo_head, fifo_next;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_has_next;

  spwr_state_t   state_q, state_d;
  spad_wr_req_t  cur_q, cur_d;
  logic [IdxW-1:0]  beat_q, beat_d;
  logic [ERR_W-1:0] err_q, err_d;
  beat_sel_t     sel;

  always_comb begin
    fifo_wdata        = '0;
    fifo_wdata.vdata  = req_vdata;
    fifo_wdata.vmask  = req_vmask;
    fifo_wdata.row    = req_row;
    fifo_wdata.col    = req_col;
    fifo_wdata.row_id = req_row_id;
    fifo_wdata.swizzle = req_swizzle;
    fifo_wdata.dtype  = dtype_t'(req_dtype);
  end

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;

  sync_fifo #(
    .WIDTH (ReqW),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .wdata    (fifo_wdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .has_next (fifo_has_next),
    .head     (fifo_head),
    .rd_next  (fifo_next)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cur_q   <= '0;
      beat_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // The request stays at the FIFO head until DONE so the FIFO depth bounds
  // the total number of outstanding requests, in-flight one included.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    beat_d   = beat_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    sel      = '0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          cur_d   = fifo_head;
          state_d = CHECK;
        end
      end
      CHECK: begin
        err_d = check_errors(cur_q);
        sel   = next_beat(cur_q, 0);
        if (err_d != '0 || !sel.found) begin
          state_d = DONE;
        end else begin
          state_d = ISSUE;
          beat_d  = sel.idx;
        end
      end
      ISSUE: begin
        if (spad_ready) begin
          sel = next_beat(cur_q, int'(beat_q) + 1);
          if (sel.found) beat_d  = sel.idx;
          else           state_d = DONE;
        end
      end
      DONE: begin
        fifo_pop = 1'b1;
        err_d    = '0;
        if (fifo_has_next) begin
          cur_d   = fifo_next;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spad_valid = (state_q == ISSUE);
    spad_row   = '0;
    spad_col   = '0;
    spad_data  = '0;
    spad_strb  = '0;
    if (spad_valid) begin
      spad_strb = beat_strb(cur_q, int'(beat_q));
      if (cur_q.swizzle) begin
        spad_row        = cur_q.row + ADDR_W'(beat_q);
        spad_col        = cur_q.col;
        spad_data[15:0] = 16'(cur_q.vdata >> (16 * int'(beat_q)));
      end else begin
        spad_row  = cur_q.row;
        spad_col  = cur_q.col + ADDR_W'(int'(beat_q) * BEAT_ELEMS);
        spad_data = BeatW'(cur_q.vdata >> (BeatW * int'(beat_q)));
      end
    end
  end

  assign done_valid  = (state_q == DONE);
  assign done_row_id = done_valid ? cur_q.row_id : '0;
  assign error       = done_valid ? err_q : '0;

endmodule

// File: tb/tb_vector_spad_writer.sv
// Bench for vector_spad_writer: directed scenarios plus random traffic checked
// against a per-request model of expected beats and completions.
module tb_vector_spad_writer;

  localparam int NE = 32;
  localparam int BE = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [511:0]  req_vdata = '0;
  logic [31:0]   req_vmask = '0;
  logic [11:0]   req_row = '0;
  logic [11:0]   req_col = '0;
  logic [5:0]    req_row_id = '0;
  logic          req_swizzle = 1'b0;
  logic [1:0]    req_dtype = '0;
  logic          spad_valid;
  logic          spad_ready = 1'b1;
  logic [11:0]   spad_row;
  logic [11:0]   spad_col;
  logic [127:0]  spad_data;
  logic [7:0]    spad_strb;
  logic          done_valid;
  logic [5:0]    done_row_id;
  logic [4:0]    error;

  vector_spad_writer dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_vdata   (req_vdata),
    .req_vmask   (req_vmask),
    .req_row     (req_row),
    .req_col     (req_col),
    .req_row_id  (req_row_id),
    .req_swizzle (req_swizzle),
    .req_dtype   (req_dtype),
    .spad_valid  (spad_valid),
    .spad_ready  (spad_ready),
    .spad_row    (spad_row),
    .spad_col    (spad_col),
    .spad_data   (spad_data),
    .spad_strb   (spad_strb),
    .done_valid  (done_valid),
    .done_row_id (done_row_id),
    .error       (error)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic [11:0]  row;
    logic [11:0]  col;
    logic [127:0] data;
    logic [7:0]   strb;
  } beat_t;

  typedef struct {
    logic [5:0] id;
    logic [4:0] err;
  } done_t;

  beat_t exp_beats[$];
  done_t exp_done[$];

  int n_checks = 0;
  int n_errors = 0;
  int beats_acc = 0;
  int valid_seen = 0;
  int done_seen = 0;
  logic [4:0] last_err = '0;
  logic [5:0] last_id = '0;
  int   ready_mode = 0;  // 0 always ready, 1 random, 2 follow man_ready
  logic man_ready = 1'b1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Expected beats/completion for one request, straight from the addressing rules.
  task automatic model_push(input logic [511:0] vd, input logic [31:0] vm, input logic [11:0] row,
                            input logic [11:0] col, input logic [5:0] id, input logic swz,
                            input logic [1:0] dt);
    done_t d;
    beat_t b;
    logic [7:0] s;
    d.id  = id;
    d.err = '0;
    if (swz && (int'(row) + NE - 1 > 4095)) d.err[0] = 1'b1;
    if (!swz && (int'(col) + NE - 1 > 4095)) d.err[1] = 1'b1;
    if (dt != 2'd0) d.err[2] = 1'b1;
    if (d.err == '0) begin
      if (swz) begin
        for (int k = 0; k < NE; k++) begin
          if (vm[k]) begin
            b.row  = 12'(int'(row) + k);
            b.col  = col;
            b.data = {112'b0, vd[16*k +: 16]};
            b.strb = 8'h01;
            exp_beats.push_back(b);
          end
        end
      end else begin
        for (int k = 0; k < NE / BE; k++) begin
          s = vm[BE*k +: BE];
          if (s != 8'h00) begin
            b.row  = row;
            b.col  = 12'(int'(col) + BE * k);
            b.data = vd[128*k +: 128];
            b.strb = s;
            exp_beats.push_back(b);
          end
        end
      end
    end
    exp_done.push_back(d);
  endtask

  task automatic send_req(input logic [511:0] vd, input logic [31:0] vm, input logic [11:0] row,
                          input logic [11:0] col, input logic [5:0] id, input logic swz,
                          input logic [1:0] dt);
    bit ok;
    ok = 1'b0;
    @(posedge CLK);
    #1;
    req_vdata = vd; req_vmask = vm; req_row = row; req_col = col;
    req_row_id = id; req_swizzle = swz; req_dtype = dt; req_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge CLK);
      if (req_ready) begin
        @(posedge CLK);
        ok = 1'b1;
      end
    end
    #1;
    req_valid = 1'b0;
    if (ok) model_push(vd, vm, row, col, id, swz, dt);
    else    check("req_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_beats.size() == 0 && exp_done.size() == 0) break;
      @(negedge CLK);
    end
    check("drain", exp_beats.size() + exp_done.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       spad_ready = 1'b1;
        1:       spad_ready = 1'($urandom_range(0, 1));
        default: spad_ready = man_ready;
      endcase
    end
  end

  // Scoreboard: accepted beats, stall stability and completions.
  initial begin
    bit    stall_q;
    beat_t held;
    beat_t b;
    done_t d;
    stall_q = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_valid", spad_valid, 1);
          check("hold_addr", {spad_row, spad_col, spad_strb}, {held.row, held.col, held.strb});
          check("hold_data", spad_data, held.data);
        end
        if (spad_valid) begin
          valid_seen++;
          check("strb_nonzero", spad_strb != 8'h00, 1);
        end
        if (spad_valid && spad_ready) begin
          beats_acc++;
          if (exp_beats.size() == 0) begin
            check("beat_unexpected", 1, 0);
          end else begin
            b = exp_beats.pop_front();
            check("beat_row", spad_row, b.row);
            check("beat_col", spad_col, b.col);
            check("beat_data", spad_data, b.data);
            check("beat_strb", spad_strb, b.strb);
          end
        end
        stall_q   = spad_valid && !spad_ready;
        held.row  = spad_row;
        held.col  = spad_col;
        held.data = spad_data;
        held.strb = spad_strb;
        if (done_valid) begin
          done_seen++;
          last_err = error;
          last_id  = done_row_id;
          if (exp_done.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            d = exp_done.pop_front();
            check("done_id", done_row_id, d.id);
            check("done_err", error, d.err);
          end
        end else begin
          check("error_idle", error, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] vd;
    int b0, v0, d0;
    bit got;

    #3;
    check("rst_req_ready", req_ready, 1);
    check("rst_spad_valid", spad_valid, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_error", error, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Row mode with latency checks
    ready_mode = 0;
    vd = rand_vec();
    b0 = beats_acc;
    send_req(vd, 32'hFFFF_FFFF, 12'd5, 12'd64, 6'd11, 1'b0, 2'd0);
    @(negedge CLK); check("lat_idle", spad_valid, 0);
    @(negedge CLK); check("lat_check", spad_valid, 0);
    @(negedge CLK); check("lat_first", spad_valid, 1);
    check("lat_first_col", spad_col, 12'd64);
    repeat (4) @(negedge CLK);
    check("done_latency", done_valid, 1);
    wait_idle(200);
    check("row_beats", beats_acc - b0, 4);
    check("row_id_echo", last_id, 6'd11);
    check("row_err", last_err, 5'b00000);

    // Swizzle, sparse mask
    b0 = beats_acc;
    send_req(rand_vec(), 32'h0000_0005, 12'd100, 12'd7, 6'd22, 1'b1, 2'd0);
    wait_idle(200);
    check("swz_beats", beats_acc - b0, 2);

    // Swizzle touching the last row exactly
    b0 = beats_acc;
    send_req(rand_vec(), 32'h8000_0000, 12'd4064, 12'd9, 6'd23, 1'b1, 2'd0);
    wait_idle(200);
    check("swz_edge_beats", beats_acc - b0, 1);
    check("swz_edge_err", last_err, 5'b00000);

    // Backpressure on beat 1
    ready_mode = 2;
    man_ready  = 1'b1;
    b0 = beats_acc;
    send_req(rand_vec(), 32'hFFFF_FFFF, 12'd300, 12'd128, 6'd33, 1'b0, 2'd0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (spad_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("bp_first_valid", got, 1);
    man_ready = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("bp_stall_col", spad_col, 12'd136);
    end
    man_ready = 1'b1;
    wait_idle(200);
    check("bp_beats", beats_acc - b0, 4);

    // Error cases
    ready_mode = 0;
    v0 = valid_seen;
    send_req(rand_vec(), 32'hFFFF_FFFF, 12'd4070, 12'd0, 6'd41, 1'b1, 2'd0);
    wait_idle(200);
    check("err_row_code", last_err, 5'b00001);
    send_req(rand_vec(), 32'hFFFF_FFFF, 12'd0, 12'd4080, 6'd42, 1'b0, 2'd0);
    wait_idle(200);
    check("err_col_code", last_err, 5'b00010);
    send_req(rand_vec(), 32'hFFFF_FFFF, 12'd0, 12'd0, 6'd43, 1'b0, 2'd2);
    wait_idle(200);
    check("err_dtype_code", last_err, 5'b00100);
    check("err_no_valid", valid_seen - v0, 0);

    // FIFO fill and ordering
    ready_mode = 2;
    man_ready  = 1'b0;
    d0 = done_seen;
    send_req(rand_vec(), 32'hFFFF_FFFF, 12'd10, 12'd0, 6'd1, 1'b0, 2'd0);
    send_req(rand_vec(), 32'h0000_00F0, 12'd11, 12'd8, 6'd2, 1'b0, 2'd0);
    fork
      send_req(rand_vec(), 32'h0000_0003, 12'd12, 12'd16, 6'd3, 1'b1, 2'd0);
      begin
        repeat (4) begin
          @(negedge CLK);
          check("fifo_full_ready", req_ready, 0);
        end
        check("fifo_no_early_done", done_seen - d0, 0);
        man_ready = 1'b1;
      end
    join
    check("fifo_third_after_done", done_seen > d0, 1);
    wait_idle(400);
    check("fifo_done_count", done_seen - d0, 3);
    check("fifo_last_id", last_id, 6'd3);

    // Reset in the middle of ISSUE
    man_ready = 1'b0;
    send_req(rand_vec(), 32'hFFFF_FFFF, 12'd20, 12'd0, 6'd50, 1'b0, 2'd0);
    send_req(rand_vec(), 32'hFFFF_FFFF, 12'd21, 12'd0, 6'd51, 1'b0, 2'd0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (spad_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_mid_valid_before", got, 1);
    #2;
    RST = 1'b1;
    #1;
    check("rst_async_valid", spad_valid, 0);
    check("rst_async_ready", req_ready, 1);
    check("rst_async_done", done_valid, 0);
    exp_beats.delete();
    exp_done.delete();
    d0 = done_seen;
    @(negedge CLK);
    #2;
    RST = 1'b0;
    man_ready = 1'b1;
    v0 = valid_seen;
    repeat (10) @(negedge CLK);
    check("rst_no_done", done_seen - d0, 0);
    check("rst_no_valid", valid_seen - v0, 0);
    check("rst_ready_after", req_ready, 1);

    // Random traffic
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] vm;
      logic [11:0] row, col;
      logic [1:0]  dt;
      case ($urandom_range(0, 3))
        0:       vm = 32'h0;
        1:       vm = 32'h1 << $urandom_range(0, 31);
        2:       vm = $urandom;
        default: vm = 32'hFFFF_FFFF;
      endcase
      row = ($urandom_range(0, 3) == 0) ? 12'(4040 + $urandom_range(0, 55))
                                        : 12'($urandom_range(0, 4095));
      col = ($urandom_range(0, 3) == 0) ? 12'(4040 + $urandom_range(0, 55))
                                        : 12'($urandom_range(0, 4095));
      dt  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      send_req(rand_vec(), vm, row, col, 6'(n), 1'($urandom_range(0, 1)), dt);
    end
    wait_idle(20000);

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
